// File: rtl/serial_pkg.sv
// serial_pkg: shared encodings and defaults for the EMC08 serial receive path.
package serial_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        M0_LOW  = 3'd1,
        M0_HIGH = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        STOP    = 3'd5,
        LOAD    = 3'd6
    } state_e;

    localparam int OVERSAMPLE_DEF  = 16;
    localparam int SAMPLE_MID_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FRAME_BITS      = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_rx_sampler.sv
// serial_rx_sampler: rxd synchroniser, falling-edge detect, 16x bit timer and 2-of-3 vote.
module serial_rx_sampler
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SAMPLE_MID  = SAMPLE_MID_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rxd_i,
    input  logic tick_i,
    input  logic clear_i,
    input  logic run_i,
    output logic rxd_sync_o,
    output logic fall_o,
    output logic vote_valid_o,
    output logic vote_o,
    output logic bit_end_o
);
    localparam int CW = $clog2(OVERSAMPLE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   prev_q, s0_q, s1_q, vote_q, valid_q, samp;

    assign samp         = tick_i & run_i;
    assign rxd_sync_o   = sync_q[SYNC_STAGES-1];
    assign fall_o       = prev_q & ~rxd_sync_o;
    assign bit_end_o    = samp && cnt_q == CW'(OVERSAMPLE-1);
    assign vote_o       = vote_q;
    assign vote_valid_o = valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            vote_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            prev_q  <= rxd_sync_o;
            valid_q <= samp && cnt_q == CW'(SAMPLE_MID+1);
            if (clear_i)
                cnt_q <= '0;
            else if (samp)
                cnt_q <= bit_end_o ? '0 : cnt_q + 1'b1;
            if (samp && cnt_q == CW'(SAMPLE_MID-1))
                s0_q <= rxd_sync_o;
            if (samp && cnt_q == CW'(SAMPLE_MID))
                s1_q <= rxd_sync_o;
            if (samp && cnt_q == CW'(SAMPLE_MID+1))
                vote_q <= majority3(s0_q, s1_q, rxd_sync_o);
        end
    end

endmodule

// File: rtl/serial_rx_control.sv
// serial_rx_control: 8051-style receive sequencer driving the input shifter in SCON modes 0-3.
module serial_rx_control
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SAMPLE_MID  = SAMPLE_MID_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic serial_clock_i,
    input  logic serial_reset_i_b,
    input  logic serial_rxd_i,
    input  logic serial_tick16_i,
    input  logic serial_mode0_tick_i,
    input  logic serial_scon7_sm0_i,
    input  logic serial_scon6_sm1_i,
    input  logic serial_scon5_sm2_i,
    input  logic serial_scon4_ren_i,
    input  logic serial_scon0_ri_i,
    output logic serial_start_input_shift_reg_o,
    output logic serial_shift_input_shift_reg_o,
    output logic serial_data_o,
    output logic serial_receive_o,
    output logic serial_load_sbuf_o,
    output logic serial_set_ri_o,
    output logic serial_rb8_o,
    output logic serial_load_rb8_o,
    output logic serial_txd_shift_clk_o
);
    localparam int BW = $clog2(FRAME_BITS + 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d, mode_in;
    logic [BW-1:0] bits_q, bits_d;
    logic start_q, start_d, shift_q, shift_d, data_q, data_d, recv_q, recv_d;
    logic load_q, load_d, set_ri_q, set_ri_d, rb8_q, rb8_d, lrb8_q, lrb8_d;
    logic clk0_q, clk0_d, hold_q, hold_d, armed_q;
    logic t16, m0_tick, clear, run, abort;
    logic rxd_sync, fall, vote_valid, vote, bit_end;

    assign mode_in = mode_e'({serial_scon7_sm0_i, serial_scon6_sm1_i});
    // Ticks are held off for the first cycle out of reset so an edge-coincident tick is ignored.
    assign t16     = serial_tick16_i & armed_q;
    assign m0_tick = serial_mode0_tick_i & armed_q;
    assign run     = state_q == START || state_q == DATA || state_q == STOP;
    assign abort   = state_q != IDLE && (!serial_scon4_ren_i || mode_in != mode_q);

    serial_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SAMPLE_MID (SAMPLE_MID),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk_i       (serial_clock_i),
        .rst_n_i     (serial_reset_i_b),
        .rxd_i       (serial_rxd_i),
        .tick_i      (t16),
        .clear_i     (clear),
        .run_i       (run),
        .rxd_sync_o  (rxd_sync),
        .fall_o      (fall),
        .vote_valid_o(vote_valid),
        .vote_o      (vote),
        .bit_end_o   (bit_end)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bits_d   = bits_q;
        start_d  = 1'b0;
        shift_d  = 1'b0;
        load_d   = 1'b0;
        set_ri_d = 1'b0;
        lrb8_d   = 1'b0;
        clear    = 1'b0;
        data_d   = data_q;
        clk0_d   = clk0_q;
        rb8_d    = rb8_q;
        // Mode 0 stays parked after a load until RI has been raised (or REN dropped).
        hold_d   = hold_q & serial_scon4_ren_i & ~serial_scon0_ri_i;
        unique case (state_q)
            IDLE: begin
                if (serial_scon4_ren_i && mode_in == MODE0 && !serial_scon0_ri_i && !hold_q) begin
                    start_d = 1'b1;
                    mode_d  = MODE0;
                    bits_d  = '0;
                    state_d = M0_LOW;
                end else if (serial_scon4_ren_i && mode_in != MODE0 && fall) begin
                    start_d = 1'b1;
                    mode_d  = mode_in;
                    bits_d  = '0;
                    clear   = 1'b1;
                    state_d = START;
                end
            end
            M0_LOW: begin
                if (m0_tick) begin
                    clk0_d  = 1'b0;
                    state_d = M0_HIGH;
                end
            end
            M0_HIGH: begin
                if (m0_tick) begin
                    clk0_d  = 1'b1;
                    data_d  = rxd_sync;
                    shift_d = 1'b1;
                    bits_d  = bits_q + 1'b1;
                    state_d = bits_q == BW'(FRAME_BITS-1) ? LOAD : M0_LOW;
                end
            end
            START: begin
                if (bit_end)
                    state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (vote_valid) begin
                    data_d  = vote;
                    shift_d = 1'b1;
                    bits_d  = bits_q + 1'b1;
                end
                if (bit_end && bits_q == BW'(FRAME_BITS))
                    state_d = STOP;
            end
            STOP: begin
                if (vote_valid) begin
                    rb8_d   = vote;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
                if (!serial_scon0_ri_i && (mode_q == MODE0 || !serial_scon5_sm2_i || rb8_q)) begin
                    load_d   = 1'b1;
                    set_ri_d = 1'b1;
                    lrb8_d   = mode_q != MODE0;
                    hold_d   = mode_q == MODE0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            shift_d  = 1'b0;
            load_d   = 1'b0;
            set_ri_d = 1'b0;
            lrb8_d   = 1'b0;
            rb8_d    = rb8_q;
            hold_d   = 1'b0;
            clk0_d   = 1'b1;
            data_d   = 1'b1;
        end
        recv_d = state_q != IDLE && state_d != IDLE;
    end

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            state_q  <= IDLE;
            mode_q   <= MODE0;
            bits_q   <= '0;
            start_q  <= 1'b0;
            shift_q  <= 1'b0;
            data_q   <= 1'b1;
            recv_q   <= 1'b0;
            load_q   <= 1'b0;
            set_ri_q <= 1'b0;
            rb8_q    <= 1'b0;
            lrb8_q   <= 1'b0;
            clk0_q   <= 1'b1;
            hold_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bits_q   <= bits_d;
            start_q  <= start_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            recv_q   <= recv_d;
            load_q   <= load_d;
            set_ri_q <= set_ri_d;
            rb8_q    <= rb8_d;
            lrb8_q   <= lrb8_d;
            clk0_q   <= clk0_d;
            hold_q   <= hold_d;
            armed_q  <= 1'b1;
        end
    end

    assign serial_start_input_shift_reg_o = start_q;
    assign serial_shift_input_shift_reg_o = shift_q;
    assign serial_data_o                  = data_q;
    assign serial_receive_o               = recv_q;
    assign serial_load_sbuf_o             = load_q;
    assign serial_set_ri_o                = set_ri_q;
    assign serial_rb8_o                   = rb8_q;
    assign serial_load_rb8_o              = lrb8_q;
    assign serial_txd_shift_clk_o         = clk0_q;

endmodule

// File: tb/tb_serial_rx_control.sv
// tb_serial_rx_control: randomized frame-level checks of serial_rx_control against a frame model.
module tb_serial_rx_control;
    logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, tick16 = 1'b0, m0tick = 1'b0;
    logic sm0 = 1'b0, sm1 = 1'b0, sm2 = 1'b0, ren = 1'b0;
    logic ri_hw = 1'b0, ri_sw = 1'b0, clr_ri = 1'b0;
    logic start_o, shift_o, data_o, recv_o, load_o, set_ri_o, rb8_o, lrb8_o, txclk_o;
    int n_tests = 0, n_fail = 0;
    int c_shift = 0, c_start = 0, c_load = 0, c_ri = 0, c_lrb8 = 0, c_both = 0, c_pair = 0, c_fall = 0;
    int b_shift = 0, b_start = 0, b_load = 0, b_ri = 0, b_lrb8 = 0, b_both = 0, b_pair = 0, b_fall = 0;
    int d16 = 0, dm0 = 0;
    logic [7:0] shreg = 8'h00, sbuf_cap = 8'h00;
    logic rb8_cap = 1'b0, txclk_prev = 1'b1;

    always #5 clk = ~clk;

    serial_rx_control dut (
        .serial_clock_i                (clk),
        .serial_reset_i_b              (rst_n),
        .serial_rxd_i                  (rxd),
        .serial_tick16_i               (tick16),
        .serial_mode0_tick_i           (m0tick),
        .serial_scon7_sm0_i            (sm0),
        .serial_scon6_sm1_i            (sm1),
        .serial_scon5_sm2_i            (sm2),
        .serial_scon4_ren_i            (ren),
        .serial_scon0_ri_i             (ri_hw | ri_sw),
        .serial_start_input_shift_reg_o(start_o),
        .serial_shift_input_shift_reg_o(shift_o),
        .serial_data_o                 (data_o),
        .serial_receive_o              (recv_o),
        .serial_load_sbuf_o            (load_o),
        .serial_set_ri_o               (set_ri_o),
        .serial_rb8_o                  (rb8_o),
        .serial_load_rb8_o             (lrb8_o),
        .serial_txd_shift_clk_o        (txclk_o)
    );

    initial begin
        forever begin
            @(negedge clk);
            d16    = (d16 + 1) % 4;
            dm0    = (dm0 + 1) % 6;
            tick16 = d16 == 0;
            m0tick = dm0 == 0;
        end
    end

    // Shifter/SBUF/SFR emulation: counts pulses and assembles the byte LSB first.
    always @(negedge clk) begin
        if (start_o) begin
            shreg = 8'h00;
            c_start++;
        end
        if (shift_o) begin
            shreg = {data_o, shreg[7:1]};
            c_shift++;
        end
        if (load_o) begin
            sbuf_cap = shreg;
            rb8_cap  = rb8_o;
            c_load++;
        end
        if (set_ri_o) c_ri++;
        if (lrb8_o) c_lrb8++;
        if (load_o && set_ri_o) c_pair++;
        if (load_o && set_ri_o && lrb8_o) c_both++;
        if (txclk_prev && !txclk_o) c_fall++;
        txclk_prev = txclk_o;
        if (set_ri_o) ri_hw = 1'b1;
        else if (clr_ri) ri_hw = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_shift = c_shift; b_start = c_start; b_load = c_load; b_ri = c_ri;
        b_lrb8 = c_lrb8; b_both = c_both; b_pair = c_pair; b_fall = c_fall;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick16) @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_shifts(input int n);
        int t = 0;
        while (c_shift - b_shift < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) chk("shift_wait_timeout", t, 0);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = fr[i];
            wait_ticks(16);
        end
    endtask

    task automatic clear_ri();
        clr_ri = 1'b1;
        wait_ticks(2);
        clr_ri = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [7:0] b, input logic ninth,
                             input logic stp, input logic sm2_v, input logic ri_pre);
        logic [10:0] fr;
        logic erb8, eld;
        int n;
        sm0 = m[1]; sm1 = m[0]; sm2 = sm2_v; ren = 1'b1; rxd = 1'b1;
        clear_ri();
        ri_sw = ri_pre;
        wait_ticks(6);
        fr   = m == 2'd1 ? {1'b1, stp, b, 1'b0} : {1'b1, ninth, b, 1'b0};
        n    = m == 2'd1 ? 10 : 11;
        erb8 = m == 2'd1 ? stp : ninth;
        eld  = !ri_pre && (!sm2_v || erb8);
        mark();
        send_bits(fr, n);
        rxd = 1'b1;
        wait_ticks(24);
        chk("frm_start", c_start - b_start, 1);
        chk("frm_shifts", c_shift - b_shift, 8);
        chk("frm_load", c_load - b_load, 32'(eld));
        chk("frm_set_ri", c_ri - b_ri, 32'(eld));
        chk("frm_load_rb8", c_lrb8 - b_lrb8, 32'(eld));
        chk("frm_coincident", c_both - b_both, 32'(eld));
        chk("frm_receive_idle", recv_o, 0);
        if (eld) begin
            chk("frm_sbuf", sbuf_cap, b);
            chk("frm_rb8", rb8_cap, erb8);
        end
        ri_sw = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m0b;
        logic [10:0] fr;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_txclk", txclk_o, 1);
        chk("rst_data", data_o, 1);
        chk("rst_receive", recv_o, 0);
        chk("rst_load", load_o, 0);
        chk("rst_set_ri", set_ri_o, 0);
        chk("rst_start", start_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(4);

        // Mode 0, 0xAD received LSB first
        m0b = 8'hAD;
        sm0 = 1'b0; sm1 = 1'b0; sm2 = 1'b1;
        mark();
        rxd = m0b[0];
        ren = 1'b1;
        for (int i = 1; i < 8; i++) begin
            wait_shifts(i);
            rxd = m0b[i];
        end
        wait_shifts(8);
        repeat (30) @(posedge clk);
        #1;
        chk("m0_start", c_start - b_start, 1);
        chk("m0_shifts", c_shift - b_shift, 8);
        chk("m0_clk_falls", c_fall - b_fall, 8);
        chk("m0_load", c_load - b_load, 1);
        chk("m0_load_with_ri", c_pair - b_pair, 1);
        chk("m0_no_load_rb8", c_lrb8 - b_lrb8, 0);
        chk("m0_sbuf", sbuf_cap, 8'hAD);
        chk("m0_txclk_idle", txclk_o, 1);
        ren = 1'b0;
        rxd = 1'b1;
        clear_ri();

        run_frame(2'd1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

        // Short low glitch in mode 1
        sm0 = 1'b0; sm1 = 1'b1; ren = 1'b1;
        wait_ticks(4);
        mark();
        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        wait_ticks(40);
        chk("gl_start", c_start - b_start, 1);
        chk("gl_shifts", c_shift - b_shift, 0);
        chk("gl_load", c_load - b_load, 0);
        chk("gl_receive", recv_o, 0);

        run_frame(2'd3, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(2'd3, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame(2'd2, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame(2'd2, 8'h5E, 1'b0, 1'b1, 1'b0, 1'b0);

        // REN dropped during data bit 4
        sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0; ren = 1'b1;
        clear_ri();
        wait_ticks(4);
        mark();
        fr = {1'b1, 1'b1, 8'h96, 1'b0};
        send_bits(fr, 5);
        chk("ab_receive_mid", recv_o, 1);
        ren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ab_receive", recv_o, 0);
        chk("ab_txclk", txclk_o, 1);
        chk("ab_data", data_o, 1);
        rxd = 1'b1;
        wait_ticks(100);
        chk("ab_shifts", c_shift - b_shift, 4);
        chk("ab_load", c_load - b_load, 0);
        ren = 1'b1;
        wait_ticks(4);

        // Reset in the middle of a mode 1 frame
        mark();
        fr = {1'b1, 1'b1, 8'h00, 1'b0};
        send_bits(fr, 4);
        rst_n = 1'b0;
        #1;
        chk("mr_receive", recv_o, 0);
        chk("mr_txclk", txclk_o, 1);
        chk("mr_data", data_o, 1);
        chk("mr_shift", shift_o, 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(120);
        chk("mr_load", c_load - b_load, 0);
        chk("mr_idle_receive", recv_o, 0);

        for (int k = 0; k < 18; k++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            run_frame(m, 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                      1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
